alarm_chime: RTL
================

# alarm_chime

Alarm and hourly-chime controller that sits directly downstream of the digital clock counter. It consumes the BCD Hour/Minute/Second outputs and holds a user-set alarm time. It drives a square-wave buzzer for the hourly time signal (four low beeps, then one high beep) and for the alarm, with snooze and stop.

## Interface
Parameters:
- CP_HZ, 4096: CP frequency in Hz; one second = CP_HZ cycles.
- LO_HALF, 4: low-tone half-period in CP cycles (512 Hz at default).
- HI_HALF, 2: high-tone half-period in CP cycles (1024 Hz at default).
- RING_SEC, 60: maximum alarm ring duration in seconds.
- SNOOZE_MIN, 5: snooze length in minutes, 1..59.

Ports:
- CP  in  1  system clock, rising edge.
- nCR  in  1  asynchronous active-low reset.
- Hour  in  8  BCD 00..23 from clock counter, synchronous to CP.
- Minute  in  8  BCD 00..59, synchronous to CP.
- Second  in  8  BCD 00..59, synchronous to CP.
- AlarmEn  in  1  level; 0 disables alarm and aborts ring/snooze.
- SetAlmMin  in  1  one-CP pulse (debounced upstream); increments alarm minute.
- SetAlmHr  in  1  one-CP pulse; increments alarm hour.
- Snooze  in  1  one-CP pulse.
- Stop  in  1  one-CP pulse.
- AlmHour  out  8  BCD alarm hour.
- AlmMinute  out  8  BCD alarm minute.
- Buzzer  out  1  tone output, registered.
- Ringing  out  1  1 in RING state, registered.

## Operation
- Reset values: AlmHour=8'h07, AlmMinute=8'h00, Buzzer=0, Ringing=0. FSM resets to IDLE, SecPrev to 8'h00, and all counters to 0.
- NewSec is high in the cycle where Second != SecPrev. SecPrev <= Second every cycle.
- Alarm setting: SetAlmMin performs a BCD increment 59->00 with no carry into the hour. SetAlmHr performs 23->00. Both pulses are legal in any FSM state and do not alter an in-progress ring or snooze target. If both fire in the same cycle, both increment.
- Chime (only when FSM is not RING):
  - On NewSec with Minute==8'h59 and Second in {51,53,55,57}, start a low-tone burst of CP_HZ/2 cycles.
  - On NewSec with Minute==8'h59 and Second==8'h59, start a high-tone burst of CP_HZ/2 cycles.
  - A new trigger restarts the burst.
- FSM states IDLE, RING, SNOOZE:
  - IDLE->RING: AlarmEn & NewSec & Second==8'h00 & Hour==AlmHour & Minute==AlmMinute. Clears the ring-second counter and aborts any chime burst.
  - RING->IDLE: Stop, or AlarmEn==0, or the ring-second counter reaching RING_SEC (counter increments on NewSec).
  - RING->SNOOZE: Snooze without Stop in the same cycle; Stop has priority. SnzHour:SnzMin <= Hour:Minute + SNOOZE_MIN minutes in BCD, with minute carry into the hour and 23:59+1 wrapping to 00:00.
  - SNOOZE->RING: NewSec & Second==8'h00 & Hour==SnzHour & Minute==SnzMin. AlarmEn is required.
  - SNOOZE->IDLE: Stop or AlarmEn==0.
  - Snooze pulses in IDLE or SNOOZE are ignored. Stop in IDLE is ignored.
- Buzzer:
  - RING: high tone gated by a half-second phase counter, 0.5 s on, 0.5 s off, starting with the on phase.
  - Chime burst active: the selected tone.
  - Otherwise 0.
- Tone generator: a half-period counter toggles Buzzer every LO_HALF or HI_HALF cycles while active. It restarts with Buzzer=1 on each burst or ring start.
- Reset mid-operation: immediate return to reset values. The alarm time also returns to 07:00.

## Timing
- Second changes at CP edge k, so NewSec is high during cycle k.
- FSM, burst start and Buzzer=1 all take effect at edge k+1 (one-cycle latency).
- Ringing rises at edge k+1 together with the first Buzzer high.
- Stop or Snooze at edge j gives Ringing=0 and Buzzer=0 at edge j+1.
- Alarm registers update at the edge after the set pulse.
- Burst length is exactly CP_HZ/2 cycles of tone, then Buzzer=0.

## Test plan
- Reset: hold nCR=0 -> AlmHour=07, AlmMinute=00, Buzzer=0, Ringing=0. Then SetAlmMin x61 -> AlmMinute=01. Then SetAlmHr x17 -> AlmHour=00.
- Chime (CP_HZ=16): drive 10:59:50..11:00:00 -> 8-cycle low bursts with period 8 at :51/:53/:55/:57, an 8-cycle high burst with period 4 at :59, silence elsewhere.
- Alarm ring: AlmHour:AlmMinute=07:00, AlarmEn=1, step Second from 06:59:59 to 07:00:00 -> Ringing=1 one cycle later. Buzzer is on/off per half-second. Ringing auto-clears after RING_SEC NewSec events.
- Snooze wrap: ring at 23:58, pulse Snooze -> target 00:03 with SNOOZE_MIN=5. Drive 00:03:00 -> Ringing=1. Stop+Snooze in the same cycle -> IDLE.
- Abort: drop AlarmEn during RING and during SNOOZE -> IDLE next cycle with Buzzer=0. A chime trigger during RING leaves the ring pattern unchanged.
- Reset mid-ring: nCR pulse while Ringing=1 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/alarm_chime.sv
// alarm_chime: hourly chime and alarm/snooze buzzer controller fed by the BCD clock counter
module alarm_chime #(
  parameter int CP_HZ      = 4096,
  parameter int LO_HALF    = 4,
  parameter int HI_HALF    = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
)(
  input  logic       CP,
  input  logic       nCR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic       AlarmEn,
  input  logic       SetAlmMin,
  input  logic       SetAlmHr,
  input  logic       Snooze,
  input  logic       Stop,
  output logic [7:0] AlmHour,
  output logic [7:0] AlmMinute,
  output logic       Buzzer,
  output logic       Ringing
);
  localparam int HALF_SEC = CP_HZ / 2;
  localparam int CW = $clog2(CP_HZ);
  localparam int HW = $clog2(LO_HALF > HI_HALF ? LO_HALF : HI_HALF) + 1;
  localparam int RW = $clog2(RING_SEC + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t        state;
  logic [7:0]    sec_prev;
  logic [6:0]    snz_h, snz_m;
  logic [RW-1:0] ring_cnt;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hc;
  logic          burst, hi_sel;

  logic          new_sec, chime_lo, chime_hi, ring_start, ring_abort, carry, hc_wrap;
  logic [6:0]    cur_h, cur_m, m_sum, snz_h_n, snz_m_n;
  logic [7:0]    alm_min_inc, alm_hr_inc;
  logic [CW-1:0] cnt_wrap;
  logic [HW-1:0] half;

  function automatic logic [6:0] bcd_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  // snooze target is kept in binary so the minute carry and midnight wrap stay simple
  always_comb begin
    new_sec     = Second != sec_prev;
    cur_h       = bcd_bin(Hour);
    cur_m       = bcd_bin(Minute);
    m_sum       = cur_m + 7'(SNOOZE_MIN);
    carry       = m_sum >= 7'd60;
    snz_m_n     = carry ? m_sum - 7'd60 : m_sum;
    snz_h_n     = !carry ? cur_h : cur_h == 7'd23 ? 7'd0 : cur_h + 7'd1;
    chime_lo    = new_sec && Minute == 8'h59 && Second inside {8'h51, 8'h53, 8'h55, 8'h57};
    chime_hi    = new_sec && Minute == 8'h59 && Second == 8'h59;
    ring_start  = AlarmEn && new_sec && Second == 8'h00 &&
                  (state == IDLE ? Hour == AlmHour && Minute == AlmMinute
                                 : state == SNOOZE && !Stop && cur_h == snz_h && cur_m == snz_m);
    ring_abort  = Stop || !AlarmEn;
    alm_min_inc = AlmMinute == 8'h59 ? 8'h00 :
                  AlmMinute[3:0] == 4'h9 ? {AlmMinute[7:4] + 4'h1, 4'h0} : AlmMinute + 8'h01;
    alm_hr_inc  = AlmHour == 8'h23 ? 8'h00 :
                  AlmHour[3:0] == 4'h9 ? {AlmHour[7:4] + 4'h1, 4'h0} : AlmHour + 8'h01;
    cnt_wrap    = cnt == CW'(CP_HZ - 1) ? '0 : cnt + 1'b1;
    half        = hi_sel ? HW'(HI_HALF) : HW'(LO_HALF);
    hc_wrap     = hc == half - 1'b1;
  end

  // cnt is the half-second phase counter while ringing and the burst length counter otherwise
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state     <= IDLE;
      sec_prev  <= 8'h00;
      AlmHour   <= 8'h07;
      AlmMinute <= 8'h00;
      snz_h     <= '0;
      snz_m     <= '0;
      ring_cnt  <= '0;
      cnt       <= '0;
      hc        <= '0;
      burst     <= 1'b0;
      hi_sel    <= 1'b0;
      Buzzer    <= 1'b0;
      Ringing   <= 1'b0;
    end else begin
      sec_prev <= Second;
      if (SetAlmMin) AlmMinute <= alm_min_inc;
      if (SetAlmHr) AlmHour <= alm_hr_inc;
      if (ring_start) begin
        state    <= RING;
        Ringing  <= 1'b1;
        Buzzer   <= 1'b1;
        ring_cnt <= '0;
        cnt      <= '0;
        hc       <= '0;
        hi_sel   <= 1'b1;
        burst    <= 1'b0;
      end else if (state == RING) begin
        if (ring_abort || Snooze || (new_sec && ring_cnt == RW'(RING_SEC - 1))) begin
          state   <= !ring_abort && Snooze ? SNOOZE : IDLE;
          snz_h   <= snz_h_n;
          snz_m   <= snz_m_n;
          Ringing <= 1'b0;
          Buzzer  <= 1'b0;
        end else begin
          if (new_sec) ring_cnt <= ring_cnt + 1'b1;
          cnt    <= cnt_wrap;
          hc     <= cnt_wrap == '0 || hc_wrap ? '0 : hc + 1'b1;
          Buzzer <= cnt_wrap == '0 || (cnt_wrap < CW'(HALF_SEC) && (hc_wrap ? !Buzzer : Buzzer));
        end
      end else begin
        if (state == SNOOZE && ring_abort) state <= IDLE;
        if (chime_lo || chime_hi) begin
          burst  <= 1'b1;
          cnt    <= '0;
          hc     <= '0;
          hi_sel <= chime_hi;
          Buzzer <= 1'b1;
        end else if (burst) begin
          burst  <= cnt != CW'(HALF_SEC - 1);
          cnt    <= cnt + 1'b1;
          hc     <= hc_wrap ? '0 : hc + 1'b1;
          Buzzer <= cnt != CW'(HALF_SEC - 1) && (hc_wrap ? !Buzzer : Buzzer);
        end
      end
    end
  end
endmodule
